// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of a 4-lane byte RAM between two requesters
module ram_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [1:0]            m0_size_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_err_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [1:0]            m1_size_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_err_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic [3:0]            wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i
);
    // The lane logic assumes exactly four byte lanes and a RAM no wider than the bus.
    if (DATA_WIDTH != 32 || RAM_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_cfg
        $error("ram_port_arbiter: unsupported DATA_WIDTH/RAM_ADDR_WIDTH");
    end

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                  state, state_nx;
    logic                    last_grant, last_grant_nx;
    logic                    owner, owner_nx;
    logic                    sel;
    logic                    s_we;
    logic [1:0]              s_size;
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic                    s_err;
    logic [3:0]              s_lanes;
    logic [1:0]              gnt, rvalid;
    logic                    err;

    // On a tie the master that did not win last time goes first; a sole requester always wins.
    assign sel     = m0_req_i ? (m1_req_i & ~last_grant) : 1'b1;
    assign s_we    = sel ? m1_we_i    : m0_we_i;
    assign s_size  = sel ? m1_size_i  : m0_size_i;
    assign s_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign s_wdata = sel ? m1_wdata_i : m0_wdata_i;
    assign s_err   = (s_size == 2'b11) | (s_size == 2'b01 & s_addr[0]) | (s_size == 2'b10 & |s_addr[1:0]);
    assign s_lanes = s_size == 2'b00 ? 4'b0001 << s_addr[1:0] :
                     s_size == 2'b01 ? 4'b0011 << {s_addr[1], 1'b0} : 4'b1111;

    // Address and data go straight from the winner; only the strobes qualify them.
    assign wr_addr_o = s_addr;
    assign rd_addr_o = s_addr;
    assign wr_data_o = s_size == 2'b00 ? {4{s_wdata[7:0]}} :
                       s_size == 2'b01 ? {2{s_wdata[15:0]}} : s_wdata;

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_err_o    = gnt[0] & err;
    assign m1_err_o    = gnt[1] & err;
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rvalid[0] ? rd_data_i : '0;
    assign m1_rdata_o  = rvalid[1] ? rd_data_i : '0;

    // State, round-robin pointer and pending read owner; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            owner      <= owner_nx;
        end
    end

    // Grant, error and RAM strobes in IDLE; read data return in RD_WAIT.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        owner_nx      = owner;
        gnt           = 2'b00;
        rvalid        = 2'b00;
        err           = 1'b0;
        wr_en_o       = 4'b0000;
        rd_en_o       = 1'b0;
        if (state == RD_WAIT) begin
            rvalid[owner] = 1'b1;
            state_nx      = IDLE;
        end else if (m0_req_i | m1_req_i) begin
            gnt[sel]      = 1'b1;
            err           = s_err;
            last_grant_nx = sel;
            if (!s_err && s_we) begin
                wr_en_o = s_lanes;
            end else if (!s_err) begin
                rd_en_o  = 1'b1;
                owner_nx = sel;
                state_nx = RD_WAIT;
            end
        end
    end
endmodule
